// File: rtl/seq_player_pkg.sv
// Shared types and character decoding for the sequence player.
// SEQ_PLAYER_XPROP_EN: 'X'/'x' and 'Z'/'z' decode to x/z nibbles instead of 0.
package seq_player_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [7:0] CH_0    = "0";
   localparam logic [7:0] CH_9    = "9";
   localparam logic [7:0] CH_UA   = "A";
   localparam logic [7:0] CH_UF   = "F";
   localparam logic [7:0] CH_LA   = "a";
   localparam logic [7:0] CH_LF   = "f";
   localparam logic [7:0] CH_USC  = "_";
   localparam logic [7:0] CH_DASH = "-";
   localparam logic [7:0] CH_UX   = "X";
   localparam logic [7:0] CH_LX   = "x";
   localparam logic [7:0] CH_UZ   = "Z";
   localparam logic [7:0] CH_LZ   = "z";

   // Returns {mask, nibble}; undefined characters give mask 0.
   function automatic logic [4:0] decode_char(input logic [7:0] ch);
      logic [4:0] r;
      r = 5'b0_0000;
      if (ch >= CH_0 && ch <= CH_9)
         r = {1'b1, 4'(ch - CH_0)};
      else if (ch >= CH_UA && ch <= CH_UF)
         r = {1'b1, 4'(ch - CH_UA + 8'd10)};
      else if (ch >= CH_LA && ch <= CH_LF)
         r = {1'b1, 4'(ch - CH_LA + 8'd10)};
      else if (ch == CH_USC)
         r = 5'b1_0000;
      else if (ch == CH_DASH)
         r = 5'b1_1111;
`ifdef SEQ_PLAYER_XPROP_EN
      else if (ch == CH_UX || ch == CH_LX)
         r = {1'b0, 4'bxxxx};
      else if (ch == CH_UZ || ch == CH_LZ)
         r = {1'b0, 4'bzzzz};
`endif
      return r;
   endfunction

endpackage

// File: rtl/seq_player_char_decode.sv
// Combinational decoder for one sequence character into a nibble and valid bit.
// Honors SEQ_PLAYER_XPROP_EN through the package decode function.
module seq_char_decode
   import seq_player_pkg::*;
(
   input  logic [7:0] ch,
   output logic [3:0] nib,
   output logic       mask
);

   logic [4:0] res;

   assign res  = decode_char(ch);
   assign mask = res[4];
   assign nib  = res[3:0];

endmodule

// File: rtl/seq_player.sv
// Plays a parameter-encoded ASCII hex sequence one step per cycle (one-shot or looping).
// SEQ_PLAYER_XPROP_EN selects x/z propagation for 'X'/'Z' characters.
module seq_player
   import seq_player_pkg::*;
#(
   parameter int                           WIDTH  = 4,
   parameter int                           NSTEPS = 8,
   parameter int                           LOOP   = 0,
   parameter logic [NSTEPS*WIDTH*2-1:0]    SEQ    = '0
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               start,
   input  logic               hold,
   input  logic               abort,
   output logic [WIDTH-1:0]   dout,
   output logic [WIDTH/4-1:0] dmask,
   output logic               busy,
   output logic               done
);

   localparam int NL  = WIDTH / 4;
   localparam int NCH = NSTEPS * NL;
   localparam int IW  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
   localparam logic [IW-1:0] LAST = IW'(NSTEPS - 1);

   state_t              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                load, keep;
   logic [WIDTH-1:0]    dout_d;
   logic [NL-1:0]       dmask_d;
   logic [NL-1:0][7:0]  ch_sel;
   logic [NL-1:0][3:0]  dec_nib;
   logic [NL-1:0]       dec_mask;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      load    = 1'b0;
      keep    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = RUN;
               idx_d   = '0;
               load    = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               idx_d   = '0;
            end else if (hold) begin
               keep = 1'b1;
            end else if (idx_q == LAST) begin
               idx_d = '0;
               if (LOOP != 0) load = 1'b1;
               else           state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
               load  = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Decode the step about to be presented; lane j holds dout nibble j,
   // which is character NL-1-j of that step (first character is the MSB).
   for (genvar j = 0; j < NL; j++) begin : g_lane
      assign ch_sel[j] = SEQ[8*(NCH-1-(int'(idx_d)*NL + (NL-1-j))) +: 8];
      seq_char_decode u_dec (
         .ch   (ch_sel[j]),
         .nib  (dec_nib[j]),
         .mask (dec_mask[j])
      );
   end

   always_comb begin
      dout_d  = '0;
      dmask_d = '0;
      if (load) begin
         dout_d  = dec_nib;
         dmask_d = dec_mask;
      end else if (keep) begin
         dout_d  = dout;
         dmask_d = dmask;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         idx_q   <= '0;
         dout    <= '0;
         dmask   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dout    <= dout_d;
         dmask   <= dmask_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player: one-shot, loop, hold, abort, reset and decode cases.
// Expected xprop result depends on SEQ_PLAYER_XPROP_EN.
module tb_seq_player;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   logic s0 = 1'b0, h0 = 1'b0, a0 = 1'b0;
   logic s1 = 1'b0, a1 = 1'b0;
   logic zero = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [3:0] d0_dout; logic [0:0] d0_mask; logic d0_busy, d0_done;
   logic [7:0] d1_dout; logic [1:0] d1_mask; logic d1_busy, d1_done;
   logic [3:0] d2_dout; logic [0:0] d2_mask; logic d2_busy, d2_done;
   logic [3:0] d3_dout; logic [0:0] d3_mask; logic d3_busy, d3_done;

   always #5 clock = ~clock;

   seq_player #(.WIDTH(4), .NSTEPS(4), .LOOP(0), .SEQ("1a_-")) u_d0 (
      .clock(clock), .resetn(resetn), .start(s0), .hold(h0), .abort(a0),
      .dout(d0_dout), .dmask(d0_mask), .busy(d0_busy), .done(d0_done));
   seq_player #(.WIDTH(8), .NSTEPS(2), .LOOP(1), .SEQ("3Cx5")) u_d1 (
      .clock(clock), .resetn(resetn), .start(s1), .hold(zero), .abort(a1),
      .dout(d1_dout), .dmask(d1_mask), .busy(d1_busy), .done(d1_done));
   seq_player #(.WIDTH(4), .NSTEPS(1), .LOOP(1), .SEQ("7")) u_d2 (
      .clock(clock), .resetn(resetn), .start(s1), .hold(zero), .abort(a1),
      .dout(d2_dout), .dmask(d2_mask), .busy(d2_busy), .done(d2_done));
   seq_player #(.WIDTH(4), .NSTEPS(1), .LOOP(1), .SEQ("x")) u_d3 (
      .clock(clock), .resetn(resetn), .start(s1), .hold(zero), .abort(a1),
      .dout(d3_dout), .dmask(d3_mask), .busy(d3_busy), .done(d3_done));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // d0 state as {dout, dmask, busy, done}
   task automatic chk0(input string tag, input logic [3:0] d, input logic m,
                       input logic b, input logic dn);
      chk(tag, {d0_dout, d0_mask, d0_busy, d0_done}, {d, m, b, dn});
   endtask

   logic [3:0] x_exp;
   logic [7:0] d1_exp [4] = '{8'h3C, 8'h05, 8'h3C, 8'h05};
   logic [1:0] m1_exp [4] = '{2'b11, 2'b01, 2'b11, 2'b01};
   logic [3:0] d0_seq [4] = '{4'd1, 4'd10, 4'd0, 4'd15};

   initial begin
`ifdef SEQ_PLAYER_XPROP_EN
      x_exp = 4'bxxxx;
`else
      x_exp = 4'b0000;
`endif
      #3;
      chk0("reset_d0", 4'd0, 1'b0, 1'b0, 1'b0);
      chk("reset_d1", {d1_dout, d1_mask, d1_busy, d1_done}, 12'h0);
      #5 resetn = 1'b1;

      // looping players: d1 alternates, d2 holds its single step, d3 decodes 'x'
      s1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         s1 = 1'b0;
         chk($sformatf("loop_dout%0d", i), d1_dout, d1_exp[i]);
         chk($sformatf("loop_mask%0d", i), d1_mask, m1_exp[i]);
         chk($sformatf("loop_busy%0d", i), {d1_busy, d1_done}, 2'b10);
         chk($sformatf("one_step%0d", i), {d2_dout, d2_mask, d2_busy}, {4'd7, 1'b1, 1'b1});
         chk($sformatf("xdec%0d", i), {d3_dout, d3_mask, d3_busy}, {x_exp, 1'b0, 1'b1});
      end
      a1 = 1'b1;
      tick();
      a1 = 1'b0;
      chk("loop_abort", {d1_dout, d1_mask, d1_busy, d1_done}, 12'h0);
      chk("one_abort", {d2_dout, d2_mask, d2_busy, d2_done}, 7'h0);
      tick();
      chk("loop_nodone", {d1_busy, d1_done}, 2'b00);

      // one-shot playback
      s0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         s0 = 1'b0;
         chk0($sformatf("oneshot%0d", i), d0_seq[i], 1'b1, 1'b1, 1'b0);
      end
      tick(); chk0("oneshot_done", 4'd0, 1'b0, 1'b0, 1'b1);
      tick(); chk0("oneshot_idle", 4'd0, 1'b0, 1'b0, 1'b0);

      // hold three cycles at step 2
      s0 = 1'b1;
      tick(); s0 = 1'b0; chk0("hold_s0", 4'd1, 1'b1, 1'b1, 1'b0);
      tick(); chk0("hold_s1", 4'd10, 1'b1, 1'b1, 1'b0);
      tick(); chk0("hold_s2", 4'd0, 1'b1, 1'b1, 1'b0);
      h0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk0($sformatf("hold_rep%0d", i), 4'd0, 1'b1, 1'b1, 1'b0);
      end
      h0 = 1'b0;
      tick(); chk0("hold_s3", 4'd15, 1'b1, 1'b1, 1'b0);
      tick(); chk0("hold_done", 4'd0, 1'b0, 1'b0, 1'b1);
      tick();

      // start held high through RUN and DONE has no effect on the sequence
      s0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk0($sformatf("restart%0d", i), d0_seq[i], 1'b1, 1'b1, 1'b0);
      end
      tick(); s0 = 1'b0; chk0("restart_done", 4'd0, 1'b0, 1'b0, 1'b1);
      tick(); chk0("restart_idle", 4'd0, 1'b0, 1'b0, 1'b0);

      // start and abort together stay idle
      s0 = 1'b1; a0 = 1'b1;
      tick(); chk0("start_abort", 4'd0, 1'b0, 1'b0, 1'b0);
      s0 = 1'b0; a0 = 1'b0;
      tick(); chk0("start_abort2", 4'd0, 1'b0, 1'b0, 1'b0);

      // abort mid-run
      s0 = 1'b1;
      tick(); s0 = 1'b0; a0 = 1'b1; chk0("abort_s0", 4'd1, 1'b1, 1'b1, 1'b0);
      tick(); a0 = 1'b0; chk0("abort_clr", 4'd0, 1'b0, 1'b0, 1'b0);
      tick(); chk0("abort_nodone", 4'd0, 1'b0, 1'b0, 1'b0);

      // asynchronous reset between edges at step 1
      s0 = 1'b1;
      tick(); s0 = 1'b0;
      tick(); chk0("rst_pre", 4'd10, 1'b1, 1'b1, 1'b0);
      resetn = 1'b0;
      #1 chk0("rst_async", 4'd0, 1'b0, 1'b0, 1'b0);
      #1 resetn = 1'b1;
      tick(); chk0("rst_idle", 4'd0, 1'b0, 1'b0, 1'b0);
      s0 = 1'b1;
      tick(); s0 = 1'b0; chk0("rst_replay0", 4'd1, 1'b1, 1'b1, 1'b0);
      tick(); chk0("rst_replay1", 4'd10, 1'b1, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
